// File: rtl/stfq_rank_compute_if.sv
// rtl/stfq_rank_compute_if.sv - upstream, PIFO enqueue and PIFO dequeue signals of the STFQ rank stage
// The slave modport faces the rank stage; the master modport faces whatever drives it.
interface stfq_rank_compute_if #(
    parameter int NUM_FLOWS    = 16,
    parameter int MAX_PRIORITY = 256,
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 8
);
    localparam int FLOW_WIDTH = $clog2(NUM_FLOWS);
    localparam int PRIO_WIDTH = $clog2(MAX_PRIORITY);

    logic                  i__data_in_valid;
    logic [FLOW_WIDTH-1:0] i__data_in_flow;
    logic [LEN_WIDTH-1:0]  i__data_in_len;
    logic [DATA_WIDTH-1:0] i__data_in;
    logic                  o__data_in_ready;

    logic                  o__data_out_valid;
    logic [PRIO_WIDTH-1:0] o__data_out_priority;
    logic [DATA_WIDTH-1:0] o__data_out;
    logic                  i__data_out_ready;

    logic                  i__deq_valid;
    logic [PRIO_WIDTH-1:0] i__deq_priority;
    logic                  i__clear_all;
    logic [PRIO_WIDTH-1:0] o__vtime;

    modport slave (
        input  i__data_in_valid, i__data_in_flow, i__data_in_len, i__data_in,
        output o__data_in_ready,
        output o__data_out_valid, o__data_out_priority, o__data_out,
        input  i__data_out_ready,
        input  i__deq_valid, i__deq_priority, i__clear_all,
        output o__vtime
    );

    modport master (
        output i__data_in_valid, i__data_in_flow, i__data_in_len, i__data_in,
        input  o__data_in_ready,
        input  o__data_out_valid, o__data_out_priority, o__data_out,
        output i__data_out_ready,
        output i__deq_valid, i__deq_priority, i__clear_all,
        input  o__vtime
    );
endinterface

// File: rtl/stfq_rank_compute.sv
// rtl/stfq_rank_compute.sv - start-time fair queueing rank computation in front of a PIFO
// Each packet is ranked by its start tag max(V, F[flow]); F[flow] then advances by the packet length.
module stfq_rank_compute #(
    parameter int NUM_FLOWS    = 16,
    parameter int MAX_PRIORITY = 256,
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    stfq_rank_compute_if.slave      bus
);
    localparam int FLOW_WIDTH = $clog2(NUM_FLOWS);
    localparam int PRIO_WIDTH = $clog2(MAX_PRIORITY);
    localparam int SUM_WIDTH  = ((PRIO_WIDTH > LEN_WIDTH) ? PRIO_WIDTH : LEN_WIDTH) + 1;
    localparam logic [SUM_WIDTH-1:0] PRIO_SAT = SUM_WIDTH'(MAX_PRIORITY - 1);

    logic [PRIO_WIDTH-1:0] f_q [NUM_FLOWS];
    logic [PRIO_WIDTH-1:0] v_q, v_d;
    logic                  out_valid_q, out_valid_d;
    logic [PRIO_WIDTH-1:0] out_prio_q, out_prio_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  in_ready;
    logic                  accept;
    logic [FLOW_WIDTH-1:0] flow;
    logic [PRIO_WIDTH-1:0] f_rd;
    logic [PRIO_WIDTH-1:0] start_tag;
    logic [SUM_WIDTH-1:0]  finish_sum;
    logic [PRIO_WIDTH-1:0] finish_tag;

    always_comb begin
        flow       = bus.i__data_in_flow;
        // A full output slot can still take a packet when the PIFO drains it this cycle.
        in_ready   = reset & ~bus.i__clear_all & (~out_valid_q | bus.i__data_out_ready);
        accept     = bus.i__data_in_valid & in_ready;
        f_rd       = f_q[flow];
        start_tag  = (v_q > f_rd) ? v_q : f_rd;
        finish_sum = SUM_WIDTH'(start_tag) + SUM_WIDTH'(bus.i__data_in_len);
        finish_tag = (finish_sum > PRIO_SAT) ? PRIO_SAT[PRIO_WIDTH-1:0]
                                             : finish_sum[PRIO_WIDTH-1:0];
    end

    always_comb begin
        v_d         = v_q;
        out_valid_d = out_valid_q;
        out_prio_d  = out_prio_q;
        out_data_d  = out_data_q;
        if (bus.i__clear_all) begin
            v_d         = '0;
            out_valid_d = 1'b0;
        end else begin
            // start_tag above already sampled the pre-update V, so a same-cycle dequeue cannot leak in.
            if (bus.i__deq_valid && (bus.i__deq_priority > v_q))
                v_d = bus.i__deq_priority;
            if (accept) begin
                out_valid_d = 1'b1;
                out_prio_d  = start_tag;
                out_data_d  = bus.i__data_in;
            end else if (out_valid_q && bus.i__data_out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FLOWS; i++)
                f_q[i] <= '0;
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out_prio_q  <= '0;
            out_data_q  <= '0;
        end else begin
            if (bus.i__clear_all) begin
                for (int i = 0; i < NUM_FLOWS; i++)
                    f_q[i] <= '0;
            end else if (accept) begin
                f_q[flow] <= finish_tag;
            end
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            out_prio_q  <= out_prio_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.o__data_in_ready     = in_ready;
    assign bus.o__data_out_valid    = out_valid_q;
    assign bus.o__data_out_priority = out_prio_q;
    assign bus.o__data_out          = out_data_q;
    assign bus.o__vtime             = v_q;
endmodule

// File: tb/tb_stfq_rank_compute.sv
// tb/tb_stfq_rank_compute.sv - directed and randomized checks of stfq_rank_compute against a tag model
module tb_stfq_rank_compute;
    localparam int NF   = 16;
    localparam int MAXP = 256;
    localparam int DW   = 8;
    localparam int LW   = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    int   m_f [NF];
    int   m_v;
    bit   m_valid;
    int   m_prio;
    int   m_data;

    stfq_rank_compute_if #(.NUM_FLOWS(NF), .MAX_PRIORITY(MAXP), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    stfq_rank_compute #(.NUM_FLOWS(NF), .MAX_PRIORITY(MAXP), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) m_f[i] = 0;
        m_v = 0;
        m_valid = 0;
        m_prio = 0;
        m_data = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(bus.o__data_out_valid), 32'(m_valid));
        check({tag, ".vtime"}, 32'(bus.o__vtime), 32'(m_v));
        if (m_valid) begin
            check({tag, ".prio"}, 32'(bus.o__data_out_priority), 32'(m_prio));
            check({tag, ".data"}, 32'(bus.o__data_out), 32'(m_data));
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input bit iv, input int flow, input int len, input int data,
                         input bit oready, input bit dv, input int dprio, input bit clr);
        bit exp_ready;
        bit acc;
        int s;
        int fin;
        bus.i__data_in_valid  = iv;
        bus.i__data_in_flow   = 4'(flow);
        bus.i__data_in_len    = 8'(len);
        bus.i__data_in        = 8'(data);
        bus.i__data_out_ready = oready;
        bus.i__deq_valid      = dv;
        bus.i__deq_priority   = 8'(dprio);
        bus.i__clear_all      = clr;
        #1;
        exp_ready = !clr && (!m_valid || oready);
        check("in_ready", 32'(bus.o__data_in_ready), 32'(exp_ready));
        acc = iv && exp_ready;
        if (clr) begin
            for (int i = 0; i < NF; i++) m_f[i] = 0;
            m_v = 0;
            m_valid = 0;
        end else begin
            if (acc) begin
                s = (m_v > m_f[flow]) ? m_v : m_f[flow];
                fin = s + len;
                if (fin > MAXP - 1) fin = MAXP - 1;
                m_f[flow] = fin;
                m_prio = s;
                m_data = data;
                m_valid = 1;
            end else if (m_valid && oready) begin
                m_valid = 0;
            end
            if (dv && dprio > m_v) m_v = dprio;
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        int cap_prio;
        int cap_data;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        reset = 1'b0;
        bus.i__data_in_valid  = 1'b1;
        bus.i__data_in_flow   = '0;
        bus.i__data_in_len    = '0;
        bus.i__data_in        = '0;
        bus.i__data_out_ready = 1'b1;
        bus.i__deq_valid      = 1'b0;
        bus.i__deq_priority   = '0;
        bus.i__clear_all      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.ready", 32'(bus.o__data_in_ready), 0);
        check("rst.valid", 32'(bus.o__data_out_valid), 0);
        check("rst.prio", 32'(bus.o__data_out_priority), 0);
        check("rst.data", 32'(bus.o__data_out), 0);
        check("rst.vtime", 32'(bus.o__vtime), 0);
        reset = 1'b1;

        // Back-to-back same flow, then zero-length packets.
        cycle(1, 3, 10, 8'hA1, 1, 0, 0, 0);
        check("r037.rank0", 32'(bus.o__data_out_priority), 0);
        cycle(1, 3, 5, 8'hA2, 1, 0, 0, 0);
        check("r037.rank10", 32'(bus.o__data_out_priority), 10);
        cycle(1, 3, 0, 8'hA3, 1, 0, 0, 0);
        check("r031.rank15", 32'(bus.o__data_out_priority), 15);
        cycle(1, 3, 0, 8'hA4, 1, 0, 0, 0);
        check("r031.len0", 32'(bus.o__data_out_priority), 15);
        idle();

        // Virtual time overtakes a flow's finish tag.
        cycle(1, 1, 20, 8'hB1, 1, 0, 0, 0);
        check("r038.rank0", 32'(bus.o__data_out_priority), 0);
        cycle(0, 0, 0, 0, 1, 1, 30, 0);
        check("r038.vtime", 32'(bus.o__vtime), 30);
        cycle(1, 1, 4, 8'hB2, 1, 0, 0, 0);
        check("r038.rank30", 32'(bus.o__data_out_priority), 30);
        cycle(1, 1, 0, 8'hB3, 1, 0, 0, 0);
        check("r038.f34", 32'(bus.o__data_out_priority), 34);

        // Saturation of the finish tag.
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        cycle(1, 2, 250, 8'hC1, 1, 0, 0, 0);
        cycle(1, 2, 20, 8'hC2, 1, 0, 0, 0);
        check("r039.rank250", 32'(bus.o__data_out_priority), 250);
        cycle(1, 2, 1, 8'hC3, 1, 0, 0, 0);
        check("r039.rank255", 32'(bus.o__data_out_priority), 255);
        idle();

        // Downstream stall holds the slot; release takes a new packet without a bubble.
        cycle(1, 5, 3, 8'hD1, 0, 0, 0, 0);
        cap_prio = int'(bus.o__data_out_priority);
        cap_data = int'(bus.o__data_out);
        for (int k = 0; k < 5; k++) cycle(1, 6, 9, 8'hD0 + k, 0, 0, 0, 0);
        check("r040.hold.prio", 32'(bus.o__data_out_priority), 32'(cap_prio));
        check("r040.hold.data", 32'(bus.o__data_out), 8'hD1);
        cycle(1, 6, 9, 8'hD9, 1, 0, 0, 0);
        check("r040.nobubble", 32'(bus.o__data_out_valid), 1);
        check("r040.newdata", 32'(bus.o__data_out), 8'hD9);
        idle();

        // Accept coincident with a dequeue uses the old V; V never decreases.
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        cycle(1, 0, 5, 8'hE1, 1, 1, 50, 0);
        check("r041.rank0", 32'(bus.o__data_out_priority), 0);
        check("r041.v50", 32'(bus.o__vtime), 50);
        cycle(0, 0, 0, 0, 1, 1, 20, 0);
        check("r041.vkeep", 32'(bus.o__vtime), 50);

        // Clear while holding a packet, then asynchronous reset mid-stall.
        cycle(1, 9, 40, 8'hF1, 0, 0, 0, 0);
        cycle(1, 9, 7, 8'hF2, 0, 0, 0, 1);
        check("r042.clr.valid", 32'(bus.o__data_out_valid), 0);
        check("r042.clr.v", 32'(bus.o__vtime), 0);
        cycle(1, 9, 7, 8'hF3, 0, 0, 0, 0);
        check("r042.clr.rank", 32'(bus.o__data_out_priority), 0);
        cycle(1, 4, 7, 8'hF4, 0, 1, 90, 0);
        #2;
        reset = 1'b0;
        #1;
        check("r042.ar.valid", 32'(bus.o__data_out_valid), 0);
        check("r042.ar.prio", 32'(bus.o__data_out_priority), 0);
        check("r042.ar.data", 32'(bus.o__data_out), 0);
        check("r042.ar.vtime", 32'(bus.o__vtime), 0);
        check("r042.ar.ready", 32'(bus.o__data_in_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int dp;
            dp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : m_v + int'($urandom_range(0, 12));
            if (dp > 255) dp = 255;
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NF - 1)),
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 24)),
                  int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) == 0, dp, $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/stfq_rank_compute.md
STFQ_RANK_COMPUTE -- requirements
Module: stfq_rank_compute

Interface
REQ-001 SHALL have parameter NUM_FLOWS, default 16, number of flows; power of two, at least 2.
REQ-002 SHALL have parameter MAX_PRIORITY, default 256, rank range; PRIO_WIDTH = $clog2(MAX_PRIORITY).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, payload width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, packet-length width; FLOW_WIDTH = $clog2(NUM_FLOWS).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-007 SHALL have port i__data_in_valid, input, 1, upstream packet offered.
REQ-008 SHALL have port i__data_in_flow, input, FLOW_WIDTH, flow id of offered packet.
REQ-009 SHALL have port i__data_in_len, input, LEN_WIDTH, length of offered packet.
REQ-010 SHALL have port i__data_in, input, DATA_WIDTH, payload of offered packet.
REQ-011 SHALL have port o__data_in_ready, output, 1, block accepts offered packet this cycle.
REQ-012 SHALL have port o__data_out_valid, output, 1, ranked packet available; drives PIFO enqueue valid.
REQ-013 SHALL have port o__data_out_priority, output, PRIO_WIDTH, computed rank (start tag).
REQ-014 SHALL have port o__data_out, output, DATA_WIDTH, payload passed through.
REQ-015 SHALL have port i__data_out_ready, input, 1, downstream PIFO ready to enqueue.
REQ-016 SHALL have port i__deq_valid, input, 1, PIFO dequeued a packet this cycle.
REQ-017 SHALL have port i__deq_priority, input, PRIO_WIDTH, rank of dequeued packet.
REQ-018 SHALL have port i__clear_all, input, 1, synchronous clear of all scheduling state.
REQ-019 SHALL have port o__vtime, output, PRIO_WIDTH, current virtual time (observability).

Function
REQ-020 SHALL hold state: finish-tag table F[NUM_FLOWS] (PRIO_WIDTH each), virtual time V, one-entry output register (valid, priority, data).
REQ-021 SHALL drive o__data_in_ready = reset & ~i__clear_all & (~o__data_out_valid | i__data_out_ready), combinationally.
REQ-022 SHALL accept a packet when i__data_in_valid & o__data_in_ready; accepted packet appears on output next cycle (latency 1).
REQ-023 SHALL compute start S = max(V, F[flow]) using register values from the accept cycle.
REQ-024 SHALL compute finish = S + len, saturating at MAX_PRIORITY-1; write to F[flow] at accept edge.
REQ-025 SHALL load output register with priority S and payload i__data_in on accept.
REQ-026 SHALL clear o__data_out_valid when output is consumed (valid & i__data_out_ready) with no new accept; accept and consume in same cycle SHALL keep valid high with new contents.
REQ-027 SHALL hold output register stable while o__data_out_valid & ~i__data_out_ready.
REQ-028 SHALL update V <= max(V, i__deq_priority) when i__deq_valid; V never decreases except on clear/reset.
REQ-029 SHALL compute S for an accept coinciding with i__deq_valid using the pre-update V.
REQ-030 SHALL forward nothing between back-to-back same-flow accepts: second accept reads F written at the prior edge (table write completes before next read).
REQ-031 SHALL treat len = 0 as finish = S.
REQ-032 SHALL on i__clear_all (sync, highest priority over accept/deq): zero F and V, clear o__data_out_valid; no accept that cycle.
REQ-033 SHALL drive o__vtime = V.

Reset
REQ-034 SHALL on reset = 0 asynchronously set F all 0, V = 0, o__data_out_valid = 0, o__data_out_priority = 0, o__data_out = 0.
REQ-035 SHALL hold o__data_in_ready = 0 while reset = 0; resume normal operation on first edge after release.
REQ-036 SHALL, on reset asserted mid-transfer, drop the held output packet without presenting it.

Verification
REQ-037 Flow 3 len 10, then flow 3 len 5, ready held 1, V=0 -> ranks 0 then 10; F[3]=15.
REQ-038 Flow 1 len 20 accepted; deq_priority 30 pulses; then flow 1 len 4 -> second rank 30 (max(V=30, F=20)); F[1]=34.
REQ-039 F[2]=250, flow 2 len 20 -> rank 250, F[2]=255 (saturated); next flow 2 packet rank 255.
REQ-040 Output valid, i__data_out_ready=0 for 5 cycles -> o__data_in_ready=0, output fields unchanged; ready=1 with new input -> new packet next cycle, no bubble.
REQ-041 Accept flow 0 same cycle as deq_priority 50 with V=0 -> rank 0; V=50 next cycle; deq_priority 20 later -> V stays 50.
REQ-042 i__clear_all with valid output and F nonzero -> next cycle valid=0, V=0, any flow len 7 ranks 0; async reset mid-stall -> all outputs 0 immediately.
